// File: rtl/inst_loader_if.sv
// Byte-stream and instruction-memory write signals of the boot loader.
// master: the loader; slave: the byte source and instruction memory.
interface inst_loader_if #(
   parameter int unsigned ABITS = 32,
   parameter int unsigned DBITS = 32
);
   logic             rx_valid;
   logic [7:0]       rx_data;
   logic             rx_ready;
   logic             mem_we;
   logic [ABITS-1:0] mem_addr;
   logic [DBITS-1:0] mem_din;

   modport master (
      input  rx_valid,
      input  rx_data,
      output rx_ready,
      output mem_we,
      output mem_addr,
      output mem_din
   );

   modport slave (
      output rx_valid,
      output rx_data,
      input  rx_ready,
      input  mem_we,
      input  mem_addr,
      input  mem_din
   );
endinterface

// File: rtl/inst_loader.sv
// Boot loader: big-endian byte stream -> instruction memory words; holds the CPU in reset.
// Define LOADER_CHECKSUM_EN to require a trailing 32-bit wrapping sum of the data words.
module inst_loader #(
   parameter int unsigned ABITS     = 32,
   parameter int unsigned DBITS     = 32,
   parameter int unsigned MAX_WORDS = 1024
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   inst_loader_if.master bus,
   output logic          cpu_rst,
   output logic          busy,
   output logic          done,
   output logic          error
);

`ifdef LOADER_CHECKSUM_EN
   typedef enum logic [2:0] {StIdle, StHdr, StData, StCsum, StDone, StError} state_e;
   localparam state_e StAfterData = StCsum;
`else
   typedef enum logic [2:0] {StIdle, StHdr, StData, StDone, StError} state_e;
   localparam state_e StAfterData = StDone;
`endif

   state_e           state_q, state_d;
   logic [1:0]       byte_cnt_q, byte_cnt_d;
   logic [23:0]      shift_q, shift_d;
   logic [31:0]      count_q, count_d;
   logic [ABITS-1:0] word_idx_q, word_idx_d;
   logic             mem_we_q, mem_we_d;
   logic [ABITS-1:0] mem_addr_q, mem_addr_d;
   logic [DBITS-1:0] mem_din_q, mem_din_d;
`ifdef LOADER_CHECKSUM_EN
   logic [31:0]      csum_q, csum_d;
`endif

   logic        rx_ready;
   logic        accept;
   logic        last_byte;
   logic [31:0] word;

   assign rx_ready  = (state_q == StHdr) || (state_q == StData)
`ifdef LOADER_CHECKSUM_EN
                      || (state_q == StCsum)
`endif
                      ;
   assign accept    = rx_ready && bus.rx_valid;
   assign last_byte = (byte_cnt_q == 2'd3);
   // Completed word as of the byte currently on the bus.
   assign word      = {shift_q, bus.rx_data};

   always_comb begin
      state_d    = state_q;
      byte_cnt_d = byte_cnt_q;
      shift_d    = shift_q;
      count_d    = count_q;
      word_idx_d = word_idx_q;
      mem_we_d   = 1'b0;
      mem_addr_d = mem_addr_q;
      mem_din_d  = mem_din_q;
`ifdef LOADER_CHECKSUM_EN
      csum_d     = csum_q;
`endif

      if (accept) begin
         shift_d    = {shift_q[15:0], bus.rx_data};
         byte_cnt_d = byte_cnt_q + 2'd1;
      end

      unique case (state_q)
         StIdle, StDone, StError: begin
            if (start) begin
               state_d    = StHdr;
               byte_cnt_d = 2'd0;
               shift_d    = '0;
               word_idx_d = '0;
`ifdef LOADER_CHECKSUM_EN
               csum_d     = '0;
`endif
            end
         end
         StHdr: begin
            if (accept && last_byte) begin
               count_d = word;
               if (word == 32'd0) begin
                  state_d = StAfterData;
               end else if (word > MAX_WORDS) begin
                  state_d = StError;
               end else begin
                  state_d = StData;
               end
            end
         end
         StData: begin
            if (accept && last_byte) begin
               mem_we_d   = 1'b1;
               mem_addr_d = word_idx_q;
               mem_din_d  = DBITS'(word);
               word_idx_d = word_idx_q + 1'b1;
`ifdef LOADER_CHECKSUM_EN
               csum_d     = csum_q + word;
`endif
               if (32'(word_idx_q) + 32'd1 == count_q) begin
                  state_d = StAfterData;
               end
            end
         end
`ifdef LOADER_CHECKSUM_EN
         StCsum: begin
            if (accept && last_byte) begin
               state_d = (word == csum_q) ? StDone : StError;
            end
         end
`endif
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= StIdle;
         byte_cnt_q <= '0;
         shift_q    <= '0;
         count_q    <= '0;
         word_idx_q <= '0;
         mem_we_q   <= 1'b0;
         mem_addr_q <= '0;
         mem_din_q  <= '0;
`ifdef LOADER_CHECKSUM_EN
         csum_q     <= '0;
`endif
      end else begin
         state_q    <= state_d;
         byte_cnt_q <= byte_cnt_d;
         shift_q    <= shift_d;
         count_q    <= count_d;
         word_idx_q <= word_idx_d;
         mem_we_q   <= mem_we_d;
         mem_addr_q <= mem_addr_d;
         mem_din_q  <= mem_din_d;
`ifdef LOADER_CHECKSUM_EN
         csum_q     <= csum_d;
`endif
      end
   end

   assign bus.rx_ready = rx_ready;
   assign bus.mem_we   = mem_we_q;
   assign bus.mem_addr = mem_addr_q;
   assign bus.mem_din  = mem_din_q;
   assign busy         = rx_ready;
   assign done         = (state_q == StDone);
   assign error        = (state_q == StError);
   assign cpu_rst      = (state_q != StDone);

endmodule

// File: tb/tb_inst_loader.sv
// Randomized self-checking bench for inst_loader against a stream-level reference model.
module tb_inst_loader;
   localparam int unsigned ABITS     = 32;
   localparam int unsigned DBITS     = 32;
   localparam int unsigned MAX_WORDS = 8;
`ifdef LOADER_CHECKSUM_EN
   localparam bit CsumEn = 1'b1;
`else
   localparam bit CsumEn = 1'b0;
`endif

   typedef logic [7:0] bytes_t[$];

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic start = 1'b0;
   logic cpu_rst, busy, done, error;

   inst_loader_if #(.ABITS(ABITS), .DBITS(DBITS)) bus ();

   inst_loader #(.ABITS(ABITS), .DBITS(DBITS), .MAX_WORDS(MAX_WORDS)) dut (
      .clk     (clk),
      .rst     (rst),
      .start   (start),
      .bus     (bus),
      .cpu_rst (cpu_rst),
      .busy    (busy),
      .done    (done),
      .error   (error)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;
   logic [63:0] wr_q[$];
   int we_run = 0;
   int we_long = 0;

   // Write monitor: records every memory write and flags strobes wider than one cycle.
   initial begin
      forever begin
         @(negedge clk);
         if (bus.mem_we === 1'b1) begin
            wr_q.push_back({bus.mem_addr, bus.mem_din});
            we_run++;
            if (we_run > 1) we_long++;
         end else begin
            we_run = 0;
         end
      end
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Reference stream: header, data words, optional checksum (sum of words, +1 when bad).
   function automatic bytes_t make_stream(input logic [31:0] n, input logic [31:0] words[$],
                                          input bit bad);
      bytes_t s;
      logic [31:0] sum;
      logic [31:0] w;
      sum = 32'd0;
      for (int k = 3; k >= 0; k--) s.push_back(n[k*8 +: 8]);
      if (n <= MAX_WORDS) begin
         for (int i = 0; i < int'(n); i++) begin
            w = words[i];
            sum = sum + w;
            for (int k = 3; k >= 0; k--) s.push_back(w[k*8 +: 8]);
         end
         if (CsumEn) begin
            w = bad ? sum + 32'd1 : sum;
            for (int k = 3; k >= 0; k--) s.push_back(w[k*8 +: 8]);
         end
      end
      return s;
   endfunction

   task automatic send_bytes(input bytes_t q, input int max_gap, output int cycles);
      int gap;
      int w;
      cycles = 0;
      foreach (q[i]) begin
         gap = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
         repeat (gap) begin
            bus.rx_valid = 1'b0;
            bus.rx_data  = 8'($urandom);
            @(posedge clk); #1;
            cycles++;
         end
         bus.rx_valid = 1'b1;
         bus.rx_data  = q[i];
         w = 0;
         while (bus.rx_ready !== 1'b1 && w < 50) begin
            @(posedge clk); #1;
            w++;
            cycles++;
         end
         if (w >= 50) begin
            check("rx_ready_timeout", 64'(bus.rx_ready), 64'd1);
            bus.rx_valid = 1'b0;
            return;
         end
         @(posedge clk); #1;
         cycles++;
      end
      bus.rx_valid = 1'b0;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic check_writes(input string tag, input logic [31:0] words[$], input int nexp);
      check({tag, "_nwrites"}, 64'(wr_q.size()), 64'(nexp));
      for (int j = 0; j < nexp && j < wr_q.size(); j++) begin
         check({tag, "_addr"}, 64'(wr_q[j][63:32]), 64'(j));
         check({tag, "_din"}, 64'(wr_q[j][31:0]), 64'(words[j]));
      end
      check({tag, "_we_width"}, 64'(we_long), 64'd0);
   endtask

   task automatic run_load(input string tag, input logic [31:0] n, input logic [31:0] words[$],
                           input bit bad, input int max_gap);
      bytes_t s;
      bit too_big;
      bit exp_err;
      int cyc;
      int nexp;
      too_big = (n > MAX_WORDS);
      exp_err = too_big || (CsumEn && bad);
      nexp    = too_big ? 0 : int'(n);
      s       = make_stream(n, words, bad);
      wr_q.delete();
      we_long = 0;
      pulse_start();
      check({tag, "_busy_start"}, 64'(busy), 64'd1);
      check({tag, "_cpu_rst_load"}, 64'(cpu_rst), 64'd1);
      send_bytes(s, max_gap, cyc);
      // Without a checksum the outcome is visible right after the final accepting edge.
      if (!CsumEn || too_big) begin
         check({tag, "_done_edge"}, 64'(done), 64'(!too_big));
         check({tag, "_error_edge"}, 64'(error), 64'(too_big));
         if (!too_big && n != 0) begin
            check({tag, "_last_we"}, 64'(bus.mem_we), 64'd1);
            check({tag, "_last_addr"}, 64'(bus.mem_addr), 64'(n - 32'd1));
            check({tag, "_cpu_rst_edge"}, 64'(cpu_rst), 64'd0);
         end
      end
      if (max_gap == 0) check({tag, "_cycles"}, 64'(cyc), 64'(s.size()));
      repeat (2) @(posedge clk);
      #1;
      check_writes(tag, words, nexp);
      check({tag, "_done"}, 64'(done), 64'(!exp_err));
      check({tag, "_error"}, 64'(error), 64'(exp_err));
      check({tag, "_cpu_rst"}, 64'(cpu_rst), 64'(exp_err));
      check({tag, "_busy"}, 64'(busy), 64'd0);
      check({tag, "_rx_ready"}, 64'(bus.rx_ready), 64'd0);
   endtask

   logic [31:0] basic[$];
   logic [31:0] empty_q[$];
   logic [31:0] rnd[$];
   bytes_t s;
   int cyc;
   logic [31:0] n;

   initial begin
      basic = '{32'h0400_0001, 32'h0801_0000, 32'hFC00_0000};
      bus.rx_valid = 1'b0;
      bus.rx_data  = 8'h00;

      // Reset with rx_valid active.
      rst = 1'b1;
      for (int i = 0; i < 3; i++) begin
         bus.rx_valid = 1'b1;
         bus.rx_data  = 8'($urandom);
         @(posedge clk); #1;
         check("rst_rx_ready", 64'(bus.rx_ready), 64'd0);
      end
      check("rst_mem_we", 64'(bus.mem_we), 64'd0);
      check("rst_mem_addr", 64'(bus.mem_addr), 64'd0);
      check("rst_mem_din", 64'(bus.mem_din), 64'd0);
      check("rst_cpu_rst", 64'(cpu_rst), 64'd1);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_done", 64'(done), 64'd0);
      check("rst_error", 64'(error), 64'd0);
      rst = 1'b0;

      // Bytes offered in IDLE must not be consumed.
      bus.rx_data = 8'hAA;
      repeat (3) begin
         @(posedge clk); #1;
         check("idle_rx_ready", 64'(bus.rx_ready), 64'd0);
      end
      bus.rx_valid = 1'b0;

      run_load("basic", 32'd3, basic, 1'b0, 0);
      run_load("backpressure", 32'd3, basic, 1'b0, 5);
      run_load("csum_bad", 32'd3, basic, 1'b1, 0);
      run_load("n_zero", 32'd0, empty_q, 1'b0, 0);
      run_load("n_too_big", MAX_WORDS + 1, basic, 1'b0, 0);

      // rx_valid in ERROR is ignored.
      bus.rx_valid = 1'b1;
      repeat (3) begin
         @(posedge clk); #1;
         check("err_rx_ready", 64'(bus.rx_ready), 64'd0);
      end
      bus.rx_valid = 1'b0;
      check("err_hold", 64'(error), 64'd1);
      check("err_no_write", 64'(wr_q.size()), 64'd0);

      // Reset after two of three words.
      s = make_stream(32'd3, basic, 1'b0);
      while (s.size() > 14) void'(s.pop_back());
      wr_q.delete();
      pulse_start();
      send_bytes(s, 0, cyc);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      check("midrst_busy", 64'(busy), 64'd0);
      check("midrst_cpu_rst", 64'(cpu_rst), 64'd1);
      check("midrst_done", 64'(done), 64'd0);
      repeat (3) @(posedge clk);
      #1;
      check("midrst_nwrites", 64'(wr_q.size()), 64'd2);
      run_load("after_rst", 32'd3, basic, 1'b0, 1);

      // start during a load is ignored.
      s = make_stream(32'd2, basic, 1'b0);
      wr_q.delete();
      we_long = 0;
      pulse_start();
      send_bytes(s[0:7], 0, cyc);
      pulse_start();
      send_bytes(s[8:$], 0, cyc);
      repeat (2) @(posedge clk);
      #1;
      check_writes("busy_start", basic, 2);
      check("busy_start_done", 64'(done), 64'd1);

      // Random loads, including oversize headers and corrupted checksums.
      for (int t = 0; t < 25; t++) begin
         rnd.delete();
         for (int i = 0; i < int'(MAX_WORDS); i++) rnd.push_back($urandom);
         if ($urandom_range(0, 7) == 0) n = MAX_WORDS + 1 + $urandom_range(0, 1000);
         else n = 32'($urandom_range(0, MAX_WORDS));
         run_load("random", n, rnd, 1'($urandom_range(0, 1)), int'($urandom_range(0, 3)));
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

   // Global watchdog so the run always terminates.
   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1);
   end
endmodule
